// File: rtl/ip_stack_pkg.sv
// Shared IP-stack types: protocol numbers, TX arbiter FSM encoding, client index, byte beat.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ip_stack_pkg;

    // IP protocol numbers carried in the IP header protocol field.
    localparam logic [7:0] PROTO_ICMP = 8'd1;
    localparam logic [7:0] PROTO_TCP  = 8'd6;
    localparam logic [7:0] PROTO_UDP  = 8'd17;

    // TX protocol arbiter states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_XFER  = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_t;

    // Index of a TX protocol client (0 = ICMP echo reply, 1 = UDP TX).
    typedef enum logic {
        CLIENT_0 = 1'b0,
        CLIENT_1 = 1'b1
    } client_idx_t;

    // One byte of a client stream.
    typedef struct packed {
        logic [7:0] dat;
        logic       vld;
        logic       last;
    } beat_t;

endpackage

// File: rtl/ip_tx_proto_arbiter_rr_arb2.sv
// Two-way round-robin picker: combinational pick, registered last-served pointer.
// Latency: pick is combinational from i_req; pointer updates on the edge where i_advance is high.
// Backpressure: none; the caller decides when a pick is consumed via i_advance.
//
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_req[1:0]     request per client
//   i_advance      the current pick has been granted; remember it as last served
//   o_any          at least one request is present
//   o_pick         winning client index
module rr_arb2
    import ip_stack_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_req,
    input  logic        i_advance,
    output logic        o_any,
    output client_idx_t o_pick
);

    client_idx_t last_q;

    always_comb begin
        o_any  = |i_req;
        o_pick = CLIENT_0;
        if (i_req == 2'b11) begin
            // Contention: the client that was not served most recently wins.
            o_pick = (last_q == CLIENT_0) ? CLIENT_1 : CLIENT_0;
        end else if (i_req[1]) begin
            o_pick = CLIENT_1;
        end
    end

    // Reset value "client 1 served last" makes client 0 win the first contention.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_q <= CLIENT_1;
        end else if (i_advance) begin
            last_q <= o_pick;
        end
    end

endmodule

// File: rtl/ip_tx_proto_arbiter.sv
// Shares the IP-layer TX byte port between ICMP (client 0) and UDP (client 1), tagging len/proto.
// Latency: grant 1 cycle after arbitration; each granted byte reaches the IP port 1 cycle later.
// Backpressure: none on bytes; i_ip_ready only gates new grants; frames are spaced by P_GAP idle cycles.
//
// Ports:
//   i_clk, i_rst                         clock, asynchronous active-high reset
//   i_cN_req / i_cN_len                  client N request and payload length (held until grant)
//   o_cN_grant                           client N owns the IP port (level)
//   i_cN_data / i_cN_valid / i_cN_last   client N byte stream
//   i_ip_ready                           IP layer can take a new frame (checked only when idle)
//   o_ip_data / o_ip_valid / o_ip_last   forwarded byte stream
//   o_ip_len / o_ip_proto                length and protocol latched at grant, held until next grant
//   o_timeout                            pulse: granted client sent nothing within P_TIMEOUT cycles
//   o_len_err                            pulse with o_ip_last: byte count differs from o_ip_len
module ip_tx_proto_arbiter
    import ip_stack_pkg::*;
#(
    parameter logic [7:0] P_C0_PROTO = PROTO_ICMP,
    parameter logic [7:0] P_C1_PROTO = PROTO_UDP,
    parameter int         P_TIMEOUT  = 16,
    parameter int         P_GAP      = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic        i_c0_req,
    input  logic [15:0] i_c0_len,
    output logic        o_c0_grant,
    input  logic [7:0]  i_c0_data,
    input  logic        i_c0_valid,
    input  logic        i_c0_last,

    input  logic        i_c1_req,
    input  logic [15:0] i_c1_len,
    output logic        o_c1_grant,
    input  logic [7:0]  i_c1_data,
    input  logic        i_c1_valid,
    input  logic        i_c1_last,

    input  logic        i_ip_ready,
    output logic [7:0]  o_ip_data,
    output logic        o_ip_valid,
    output logic        o_ip_last,
    output logic [15:0] o_ip_len,
    output logic [7:0]  o_ip_proto,
    output logic        o_timeout,
    output logic        o_len_err
);

    localparam int TW = $clog2(P_TIMEOUT + 1);
    localparam int GW = $clog2(P_GAP + 1);

    // Terminal counter values; each counter stops here and the FSM leaves the state.
    localparam logic [TW-1:0] TMO_TERM = TW'(P_TIMEOUT);
    localparam logic [GW-1:0] GAP_TERM = GW'(P_GAP);

    arb_state_t  state_q;
    arb_state_t  state_d;
    client_idx_t gnt_idx_q;

    logic [TW-1:0] tmo_cnt_q;
    logic [TW-1:0] tmo_cnt_inc;
    logic [GW-1:0] gap_cnt_q;
    logic [GW-1:0] gap_cnt_inc;
    logic [15:0]   byte_cnt_q;
    logic [15:0]   byte_cnt_inc;

    beat_t       c0_beat;
    beat_t       c1_beat;
    beat_t       beat;

    logic        arb_any;
    client_idx_t arb_pick;

    logic        grant_start;
    logic        beat_fire;
    logic        frame_end;
    logic        tmo_hit;
    logic        owner_active;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    rr_arb2 u_rr_arb2 (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_req     ({i_c1_req, i_c0_req}),
        .i_advance (grant_start),
        .o_any     (arb_any),
        .o_pick    (arb_pick)
    );

    // ------------------------------------------------------------------
    // Granted-client stream select. Only the owner's beat is ever looked
    // at, so the other client's valid/data/last cannot leak through.
    // ------------------------------------------------------------------
    assign c0_beat = {i_c0_data, i_c0_valid, i_c0_last};
    assign c1_beat = {i_c1_data, i_c1_valid, i_c1_last};
    assign beat    = (gnt_idx_q == CLIENT_1) ? c1_beat : c0_beat;

    assign owner_active = (state_q == ST_GRANT) || (state_q == ST_XFER);
    assign o_c0_grant   = owner_active && (gnt_idx_q == CLIENT_0);
    assign o_c1_grant   = owner_active && (gnt_idx_q == CLIENT_1);

    assign tmo_cnt_inc  = tmo_cnt_q + TW'(1);
    assign gap_cnt_inc  = gap_cnt_q + GW'(1);
    assign byte_cnt_inc = byte_cnt_q + 16'd1;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_start = 1'b0;
        beat_fire   = 1'b0;
        frame_end   = 1'b0;
        tmo_hit     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_ip_ready && arb_any) begin
                    grant_start = 1'b1;
                    state_d     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (beat.vld) begin
                    // First byte is forwarded right away; a one-byte frame
                    // goes straight to the gap.
                    beat_fire = 1'b1;
                    if (beat.last) begin
                        frame_end = 1'b1;
                        state_d   = ST_GAP;
                    end else begin
                        state_d   = ST_XFER;
                    end
                end else if (tmo_cnt_inc == TMO_TERM) begin
                    tmo_hit = 1'b1;
                    state_d = ST_GAP;
                end
            end
            ST_XFER: begin
                if (beat.vld) begin
                    beat_fire = 1'b1;
                    if (beat.last) begin
                        frame_end = 1'b1;
                        state_d   = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_inc == GAP_TERM) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tmo_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            byte_cnt_q <= '0;
        end else begin
            // Cycles spent waiting for the first byte; saturates at the terminal value.
            if (grant_start) begin
                tmo_cnt_q <= '0;
            end else if ((state_q == ST_GRANT) && !beat.vld && (tmo_cnt_q != TMO_TERM)) begin
                tmo_cnt_q <= tmo_cnt_inc;
            end

            // Gap cycles; only runs while in the gap state.
            if (state_q != ST_GAP) begin
                gap_cnt_q <= '0;
            end else if (gap_cnt_q != GAP_TERM) begin
                gap_cnt_q <= gap_cnt_inc;
            end

            // Bytes forwarded in the current frame.
            if (grant_start) begin
                byte_cnt_q <= '0;
            end else if (beat_fire) begin
                byte_cnt_q <= byte_cnt_inc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Grant latch and registered IP-side outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            gnt_idx_q  <= CLIENT_0;
            o_ip_len   <= '0;
            o_ip_proto <= '0;
            o_ip_data  <= '0;
            o_ip_valid <= 1'b0;
            o_ip_last  <= 1'b0;
            o_timeout  <= 1'b0;
            o_len_err  <= 1'b0;
        end else begin
            if (grant_start) begin
                gnt_idx_q  <= arb_pick;
                o_ip_len   <= (arb_pick == CLIENT_1) ? i_c1_len : i_c0_len;
                o_ip_proto <= (arb_pick == CLIENT_1) ? P_C1_PROTO : P_C0_PROTO;
            end

            o_ip_valid <= beat_fire;
            o_ip_data  <= beat_fire ? beat.dat : 8'h00;
            o_ip_last  <= beat_fire & beat.last;
            o_timeout  <= tmo_hit;
            // Count includes the last byte itself; frame is forwarded untouched either way.
            o_len_err  <= frame_end & (byte_cnt_inc != o_ip_len);
        end
    end

endmodule

// File: tb/tb_ip_tx_proto_arbiter.sv
module tb_ip_tx_proto_arbiter;

    localparam int P_TIMEOUT = 16;
    localparam int P_GAP     = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        c0_req, c0_valid, c0_last, c0_grant;
    logic [15:0] c0_len;
    logic [7:0]  c0_data;
    logic        c1_req, c1_valid, c1_last, c1_grant;
    logic [15:0] c1_len;
    logic [7:0]  c1_data;
    logic        ip_ready;
    logic [7:0]  ip_data, ip_proto;
    logic        ip_valid, ip_last, timeout, len_err;
    logic [15:0] ip_len;

    ip_tx_proto_arbiter #(
        .P_C0_PROTO (8'd1),
        .P_C1_PROTO (8'd17),
        .P_TIMEOUT  (P_TIMEOUT),
        .P_GAP      (P_GAP)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_c0_req   (c0_req),
        .i_c0_len   (c0_len),
        .o_c0_grant (c0_grant),
        .i_c0_data  (c0_data),
        .i_c0_valid (c0_valid),
        .i_c0_last  (c0_last),
        .i_c1_req   (c1_req),
        .i_c1_len   (c1_len),
        .o_c1_grant (c1_grant),
        .i_c1_data  (c1_data),
        .i_c1_valid (c1_valid),
        .i_c1_last  (c1_last),
        .i_ip_ready (ip_ready),
        .o_ip_data  (ip_data),
        .o_ip_valid (ip_valid),
        .o_ip_last  (ip_last),
        .o_ip_len   (ip_len),
        .o_ip_proto (ip_proto),
        .o_timeout  (timeout),
        .o_len_err  (len_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: who was served last, and how many more cycles
    // the port stays unavailable (gap plus one arbitration cycle) after a frame.
    int rr_last  = 1;
    int gap_left = 0;

    // Expected IP-side outputs for the next sampling point (1-cycle latency).
    logic       exp_vld, exp_last, exp_err, exp_tmo;
    logic [7:0] exp_dat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input int c, input logic v, input logic [7:0] d, input logic l);
        if (c == 0) begin c0_valid = v; c0_data = d; c0_last = l; end
        else        begin c1_valid = v; c1_data = d; c1_last = l; end
    endtask

    // Advance one cycle and compare the IP port against the model.
    task automatic step();
        @(negedge clk);
        if (gap_left > 0) gap_left--;
        check("ip_valid", ip_valid, exp_vld);
        if (exp_vld) check("ip_data", ip_data, exp_dat);
        check("ip_last", ip_last, exp_last);
        check("len_err", len_err, exp_err);
        check("timeout", timeout, exp_tmo);
        check("grant_onehot", c0_grant & c1_grant, 0);
        exp_vld = 0; exp_dat = 0; exp_last = 0; exp_err = 0; exp_tmo = 0;
    endtask

    task automatic noise(input int c, input bit en);
        if (en) drive(c, 1'($urandom), 8'($urandom), 1'($urandom));
        else    drive(c, 1'b0, 8'h00, 1'b0);
    endtask

    // One arbitration + frame. nbytes <= 0 means "send exactly the requested length".
    // rst_at > 0 asserts reset right after that many bytes were forwarded.
    task automatic serve(input int mask, input int len0, input int len1, input int nbytes,
                         input int idle_pct, input bit tmo_case, input bit nz, input int rst_at);
        int winner, loser, exp_wait, waited, len_w, nb, sent;
        logic [7:0] d;
        logic       l;
        if (mask == 3) winner = 1 - rr_last;
        else           winner = (mask == 2) ? 1 : 0;
        loser    = 1 - winner;
        len_w    = (winner == 1) ? len1 : len0;
        nb       = (nbytes <= 0) ? len_w : nbytes;
        exp_wait = (gap_left > 1) ? gap_left : 1;

        c0_req = mask[0]; c0_len = 16'(len0);
        c1_req = mask[1]; c1_len = 16'(len1);
        ip_ready = 1'b1;

        waited = 0;
        do begin step(); waited++; end
        while (!(c0_grant || c1_grant) && waited < 40);
        check("grant_wait", waited, exp_wait);
        check("grant_who", {c1_grant, c0_grant}, (winner == 1) ? 2 : 1);
        check("ip_proto", ip_proto, (winner == 1) ? 17 : 1);
        check("ip_len", ip_len, len_w);
        rr_last = winner;
        if (winner == 0) c0_req = 1'b0; else c1_req = 1'b0;

        if (tmo_case) begin
            for (int i = 1; i < P_TIMEOUT; i++) begin
                noise(loser, nz);
                step();
                check("grant_hold_tmo", {c1_grant, c0_grant}, (winner == 1) ? 2 : 1);
            end
            exp_tmo = 1;
            step();
            check("grant_drop_tmo", {c1_grant, c0_grant}, 0);
        end else begin
            sent = 0;
            while (sent < nb) begin
                if (sent > 0 && $urandom_range(0, 99) < idle_pct) begin
                    drive(winner, 1'b0, 8'($urandom), 1'($urandom));
                end else begin
                    d = 8'($urandom);
                    l = (sent == nb - 1);
                    drive(winner, 1'b1, d, l);
                    exp_vld = 1; exp_dat = d; exp_last = l;
                    exp_err = l && (nb != len_w);
                    sent++;
                end
                noise(loser, nz);
                if (sent > 1) ip_ready = 1'($urandom);
                step();
                if (rst_at > 0 && sent == rst_at) begin
                    #2 rst = 1'b1;
                    #1;
                    check("rst_valid", ip_valid, 0);
                    check("rst_last", ip_last, 0);
                    check("rst_grant", {c1_grant, c0_grant}, 0);
                    check("rst_len", ip_len, 0);
                    check("rst_proto", ip_proto, 0);
                    c0_req = 0; c1_req = 0;
                    drive(0, 0, 0, 0); drive(1, 0, 0, 0);
                    @(negedge clk); @(negedge clk);
                    rst = 1'b0;
                    rr_last = 1; gap_left = 0;
                    return;
                end
                if (sent < nb)
                    check("grant_hold", {c1_grant, c0_grant}, (winner == 1) ? 2 : 1);
            end
            check("grant_drop", {c1_grant, c0_grant}, 0);
            check("len_held", ip_len, len_w);
        end
        drive(0, 0, 0, 0); drive(1, 0, 0, 0);
        ip_ready = 1'b1;
        gap_left = P_GAP + 1;
    endtask

    initial begin
        int m;
        exp_vld = 0; exp_dat = 0; exp_last = 0; exp_err = 0; exp_tmo = 0;
        rst = 1'b1; ip_ready = 1'b1;
        c0_req = 0; c0_len = 0; c1_req = 0; c1_len = 0;
        drive(0, 0, 0, 0); drive(1, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("reset_valid", ip_valid, 0);
        check("reset_grants", {c1_grant, c0_grant}, 0);
        check("reset_len", ip_len, 0);
        check("reset_proto", ip_proto, 0);
        check("reset_pulses", {timeout, len_err, ip_last}, 0);
        check("reset_data", ip_data, 0);
        rst = 1'b0;

        // Simultaneous requests, three rounds: c0, c1, c0.
        for (int r = 0; r < 3; r++) serve(3, 8, 8, -1, 0, 0, 0, 0);

        // Single contiguous ICMP frame with c1 chatter while c0 owns the port.
        serve(1, 40, 0, 40, 0, 0, 1, 0);

        // Timeout on c1, then c0 wins the following contention.
        serve(2, 0, 12, -1, 0, 1, 1, 0);
        serve(3, 6, 9, -1, 30, 0, 1, 0);

        // Length mismatch: too many and too few bytes.
        serve(2, 0, 10, 12, 20, 0, 0, 0);
        serve(2, 0, 10, 8, 20, 0, 0, 0);

        // IP not ready: both requesting, no grant until ready rises.
        ip_ready = 1'b0; c0_req = 1; c1_req = 1; c0_len = 5; c1_len = 5;
        for (int i = 0; i < 8; i++) begin
            step();
            check("no_grant_not_ready", {c1_grant, c0_grant}, 0);
        end
        serve(3, 5, 5, -1, 0, 0, 1, 0);

        // Randomized frames with random idle spacing.
        for (int r = 0; r < 10; r++) begin
            m = $urandom_range(1, 3);
            serve(m, $urandom_range(1, 24), $urandom_range(1, 24),
                  ($urandom_range(0, 2) == 0) ? $urandom_range(1, 24) : -1,
                  25, ($urandom_range(0, 5) == 0), 1, 0);
            c0_req = 0; c1_req = 0;
            for (int i = $urandom_range(0, 6); i > 0; i--) step();
        end

        // Reset at byte 5 of a 40-byte c0 frame; afterwards c0 wins contention again.
        serve(1, 40, 0, 40, 0, 0, 0, 5);
        serve(3, 7, 7, -1, 10, 0, 0, 0);
        repeat (P_GAP + 2) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ip_tx_proto_arbiter.md
Name: ip_tx_proto_arbiter

Overview:
- Shares the single IP-layer transmit byte port between two protocol sources: client 0 is the ICMP echo-reply generator, client 1 is the UDP TX path.
- Clients request with a frame length. The arbiter grants one client at a time, using round-robin when both request.
- While granted, the arbiter forwards that client's byte stream to the IP layer, tagged with the IP protocol number and the payload length latched at grant.
- Enforces an inter-frame gap, a start-of-frame timeout and a length check.

Parameters:
- P_C0_PROTO, 8'd1, IP protocol number driven while client 0 is granted (ICMP).
- P_C1_PROTO, 8'd17, IP protocol number driven while client 1 is granted (UDP).
- P_TIMEOUT, 16, max cycles from grant assertion to the first client valid byte.
- P_GAP, 4, idle cycles inserted after every frame end or timeout before the next grant.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; asynchronous, active-high
- i_c0_req  in  1  client 0 request; held high until grant
- i_c0_len  in  16  client 0 payload length in bytes; valid while i_c0_req
- o_c0_grant  out  1  client 0 granted; level signal
- i_c0_data  in  8  client 0 byte
- i_c0_valid  in  1  client 0 byte valid
- i_c0_last  in  1  client 0 last byte; qualified by valid
- i_c1_req, i_c1_len, o_c1_grant, i_c1_data, i_c1_valid, i_c1_last: same as client 0, for client 1
- i_ip_ready  in  1  IP layer idle, able to accept a new frame
- o_ip_data  out  8  forwarded byte
- o_ip_valid  out  1  forwarded byte valid
- o_ip_last  out  1  forwarded last byte
- o_ip_len  out  16  latched payload length of the current frame
- o_ip_proto  out  8  latched protocol number of the current frame
- o_timeout  out  1  one-cycle pulse: granted client never started
- o_len_err  out  1  one-cycle pulse, aligned with o_ip_last: byte count differs from latched length

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; round-robin pointer selects client 0 first; all counters 0.
- FSM states: IDLE, GRANT, XFER, GAP.
- IDLE -> GRANT: when i_ip_ready=1 and at least one request is high.
  - Single requester: that client wins.
  - Both requesting: the client not served last wins; after reset, client 0 wins.
  - On this transition: latch the winner's len to o_ip_len and its protocol parameter to o_ip_proto; assert that client's grant on the next cycle.
  - Exactly one grant is high at a time, or none.
- GRANT -> XFER: on the granted client's first valid byte. That byte is already forwarded.
- GRANT -> GAP: after P_TIMEOUT cycles with no valid. Drop the grant, pulse o_timeout, and update the pointer as if the client was served.
- XFER: each granted valid byte is registered to o_ip_data/o_ip_valid/o_ip_last with 1-cycle latency.
  - Valid low cycles inside a frame are allowed and propagate as o_ip_valid=0.
  - A byte counter (16-bit) increments per valid byte.
- XFER -> GAP: on the granted client's valid&last.
  - Grant drops the cycle after last is sampled.
  - If the count including the last byte is not equal to o_ip_len, pulse o_len_err with o_ip_last. The frame is still forwarded; no truncation or padding.
- GAP: wait P_GAP cycles with outputs invalid, then go to IDLE.
  - o_ip_len and o_ip_proto hold their value until the next grant latch.
- Ungranted clients: valid, data and last are ignored and never reach the output.
- A request arriving during GRANT, XFER or GAP waits. A request dropped before grant is simply not served.
- i_ip_ready is checked only in IDLE. Deassertion mid-frame has no effect; the clients have no backpressure.
- Asynchronous reset mid-frame: immediate return to IDLE, grants low, o_ip_valid/o_ip_last low; no partial-frame flush.
- Counter widths: timeout counter ceil(log2(P_TIMEOUT+1)); gap counter ceil(log2(P_GAP+1)). Neither counter wraps; each saturates at its terminal value and triggers the transition.

Decomposition:
- Shared package ip_stack_pkg holds:
  - protocol constants: ICMP=1, UDP=17, TCP=6
  - FSM state encoding
  - client-index typedef
- One natural sub-module: rr_arb2, a 2-way round-robin picker with a last-served pointer (combinational pick plus registered pointer).
- The FSM, counters and output mux stay in the top module.

Test Plan:
- Single ICMP frame: c0_req with len=40, ip_ready=1, 40 contiguous bytes, last on byte 40 -> o_c0_grant high, 40 output bytes each delayed 1 cycle, o_ip_proto=1, o_ip_len=40, o_ip_last on byte 40, no errors.
- Simultaneous requests: c0 and c1 asserted in the same cycle, three rounds, len 8 each -> grant order c0, c1, c0; each frame is separated by 4 idle cycles.
- Timeout: c1 granted but never asserts valid -> o_timeout pulses 16 cycles after grant rises, grant drops, c0 is served next.
- Length mismatch: c1 len=10 but last on byte 12 -> all 12 bytes forwarded, o_len_err pulses with o_ip_last; c1 len=10 with last on byte 8 -> 8 bytes forwarded, o_len_err pulses.
- Isolation and ready: c1 drives valid while c0 is granted -> no c1 bytes appear on the output; ip_ready=0 with both requesting -> no grant until ready rises.
- Reset mid-frame: i_rst asserted at byte 5 of a 40-byte frame -> all outputs 0 immediately; after release, a new c0 request is granted first.
